// File: rtl/gray_codec_seq.sv
// gray_codec_seq: handshaked Gray-code converter with a per-transaction mode.
//   Mode 0 converts binary to Gray in one cycle.
//   Mode 1 converts Gray to binary bit-serially. It resolves one bit per clock, from the MSB
//   down, which keeps the long XOR chain off the critical path.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   producer has a request
//   in_ready   block can accept a request (IDLE and not in reset)
//   in_mode    0 = binary-to-Gray, 1 = Gray-to-binary
//   in_data    value to convert
//   out_valid  result available (registered)
//   out_ready  consumer accepts result
//   out_data   converted value (registered)
//   out_mode   mode of the transaction that produced out_data (registered)
//   busy       high in any state other than IDLE
module gray_codec_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             busy
);

  localparam int unsigned IdxW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StHold
  } state_e;

  state_e            r_state, w_state_d;
  logic [WIDTH-1:0]  r_out_data, w_out_data_d;
  logic              r_out_valid, w_out_valid_d;
  logic              r_out_mode, w_out_mode_d;
  logic [WIDTH-1:0]  r_g, w_g_d;
  logic [IdxW-1:0]   r_idx, w_idx_d;

  logic              w_in_ready;
  logic              w_accept;
  logic [WIDTH-1:0]  w_shift;

  assign w_in_ready = (r_state == StIdle) && rst_n;
  assign w_accept   = in_valid && w_in_ready;
  // Bit i+1 of the partial result, aligned to position i.
  assign w_shift    = r_out_data >> 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_mode  <= 1'b0;
      r_g         <= '0;
      r_idx       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_out_data  <= w_out_data_d;
      r_out_valid <= w_out_valid_d;
      r_out_mode  <= w_out_mode_d;
      r_g         <= w_g_d;
      r_idx       <= w_idx_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_out_data_d  = r_out_data;
    w_out_valid_d = r_out_valid;
    w_out_mode_d  = r_out_mode;
    w_g_d         = r_g;
    w_idx_d       = r_idx;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (!in_mode) begin
            w_out_data_d  = in_data ^ (in_data >> 1);
            w_out_mode_d  = 1'b0;
            w_out_valid_d = 1'b1;
            w_state_d     = StHold;
          end else begin
            // The MSB of binary equals the MSB of Gray; lower bits are resolved in StConv.
            w_g_d                   = in_data;
            w_out_data_d            = '0;
            w_out_data_d[WIDTH-1]   = in_data[WIDTH-1];
            w_idx_d                 = IdxW'(WIDTH - 2);
            w_out_mode_d            = 1'b1;
            w_state_d               = StConv;
          end
        end
      end
      StConv: begin
        w_out_data_d[r_idx] = w_shift[r_idx] ^ r_g[r_idx];
        if (r_idx == '0) begin
          w_out_valid_d = 1'b1;
          w_state_d     = StHold;
        end else begin
          w_idx_d = r_idx - 1'b1;
        end
      end
      StHold: begin
        if (out_ready) begin
          w_out_valid_d = 1'b0;
          w_state_d     = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign in_ready  = w_in_ready;
  assign busy      = (r_state != StIdle);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_mode  = r_out_mode;

endmodule

// File: tb/tb_gray_codec_seq.sv
// Bench for gray_codec_seq: a 4-bit and an 8-bit instance share clock and reset. Drivers push
// hand-computed expected results into per-instance queues; negedge monitors pop and compare
// whenever a result handshake is presented.
module tb_gray_codec_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode, a_busy;
  logic [3:0] a_in_data, a_out_data;
  logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode, b_busy;
  logic [7:0] b_in_data, b_out_data;

  gray_codec_seq #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_mode   (a_in_mode),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_mode  (a_out_mode),
    .busy      (a_busy)
  );

  gray_codec_seq #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_mode   (b_in_mode),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_mode  (b_out_mode),
    .busy      (b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] q4[$];
  logic [8:0] q8[$];
  logic [4:0] e4;
  logic [8:0] e8;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: compare on every cycle a result is handed over.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL w4_unexpected: got %0h expected none", a_out_data);
      end else begin
        e4 = q4.pop_front();
        chk("w4_data", 32'(a_out_data), 32'(e4[3:0]));
        chk("w4_mode", 32'(a_out_mode), 32'(e4[4]));
      end
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL w8_unexpected: got %0h expected none", b_out_data);
      end else begin
        e8 = q8.pop_front();
        chk("w8_data", 32'(b_out_data), 32'(e8[7:0]));
        chk("w8_mode", 32'(b_out_mode), 32'(e8[8]));
      end
    end
  end

  task automatic send4(input logic m, input logic [3:0] d, input logic [3:0] exp, input int lat,
                       input string nm);
    int  k;
    bit  ok;
    @(posedge clk);
    #1;
    a_in_valid = 1'b1;
    a_in_mode  = m;
    a_in_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (a_in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      chk({nm, "_accept_timeout"}, 32'(a_in_ready), 32'd1);
      a_in_valid = 1'b0;
      return;
    end
    q4.push_back({m, exp});
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_in_data  = '0;
    k  = 1;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (a_out_valid) begin
        ok = 1'b1;
        break;
      end
      chk({nm, "_busy"}, 32'(a_busy), 32'd1);
      k++;
      @(posedge clk);
    end
    if (!ok) begin
      chk({nm, "_valid_timeout"}, 32'(a_out_valid), 32'd1);
      return;
    end
    chk({nm, "_latency"}, 32'(k), 32'(lat));
    if (a_out_ready) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_ready_after"}, 32'(a_in_ready), 32'd1);
    end
  endtask

  task automatic send8(input logic m, input logic [7:0] d, input logic [7:0] exp, input int lat,
                       input string nm);
    int  k;
    bit  ok;
    @(posedge clk);
    #1;
    b_in_valid = 1'b1;
    b_in_mode  = m;
    b_in_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (b_in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      chk({nm, "_accept_timeout"}, 32'(b_in_ready), 32'd1);
      b_in_valid = 1'b0;
      return;
    end
    q8.push_back({m, exp});
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_in_data  = '0;
    k  = 1;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (b_out_valid) begin
        ok = 1'b1;
        break;
      end
      chk({nm, "_busy"}, 32'(b_busy), 32'd1);
      k++;
      @(posedge clk);
    end
    if (!ok) begin
      chk({nm, "_valid_timeout"}, 32'(b_out_valid), 32'd1);
      return;
    end
    chk({nm, "_latency"}, 32'(k), 32'(lat));
    if (b_out_ready) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_ready_after"}, 32'(b_in_ready), 32'd1);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_mode   = 1'b0;
    a_in_data   = '0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_in_mode   = 1'b0;
    b_in_data   = '0;
    b_out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_out_mode", 32'(a_out_mode), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_w8_valid", 32'(b_out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(a_in_ready), 32'd1);

    // Single transactions, both modes, both widths
    send4(1'b0, 4'b1001, 4'b1101, 1, "t1_b2g");
    send4(1'b1, 4'b1101, 4'b1001, 4, "t2_g2b");
    send8(1'b0, 8'hA5, 8'hF7, 1, "t3_b2g8");
    send8(1'b1, 8'hF7, 8'hA5, 8, "t3_g2b8");

    // Boundary values
    send4(1'b0, 4'b1111, 4'b1000, 1, "t4_b2g_ones");
    send4(1'b0, 4'b0000, 4'b0000, 1, "t4_b2g_zero");
    send4(1'b1, 4'b1111, 4'b1010, 4, "t4_g2b_ones");
    send4(1'b1, 4'b1000, 4'b1111, 4, "t4_g2b_msb");

    // Backpressure: result held, second request waits
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_mode   = 1'b0;
    a_in_data   = 4'b0110;
    @(negedge clk);
    chk("bp_first_ready", 32'(a_in_ready), 32'd1);
    q4.push_back({1'b0, 4'b0101});
    @(posedge clk);
    #1;
    a_in_data = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_ready", 32'(a_in_ready), 32'd0);
      chk("bp_hold_valid", 32'(a_out_valid), 32'd1);
      chk("bp_hold_data", 32'(a_out_data), 32'b0101);
      @(posedge clk);
      #1;
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(a_in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_second_ready", 32'(a_in_ready), 32'd1);
    q4.push_back({1'b0, 4'b0010});
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", 32'(a_out_valid), 32'd1);

    // Reset in the middle of a Gray-to-binary conversion
    @(posedge clk);
    #1;
    a_in_valid = 1'b1;
    a_in_mode  = 1'b1;
    a_in_data  = 4'b1101;
    @(negedge clk);
    chk("mr_accept_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("mr_busy_conv", 32'(a_busy), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_ready_in_rst", 32'(a_in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mr_out_valid", 32'(a_out_valid), 32'd0);
    chk("mr_out_data", 32'(a_out_data), 32'd0);
    chk("mr_out_mode", 32'(a_out_mode), 32'd0);
    chk("mr_busy", 32'(a_busy), 32'd0);
    chk("mr_in_ready", 32'(a_in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send4(1'b1, 4'b0011, 4'b0010, 4, "t6_after_rst");

    // Drain: every pushed expectation must have been consumed
    for (int t = 0; t < 20; t++) begin
      if (q4.size() == 0 && q8.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_q4", 32'(q4.size()), 32'd0);
    chk("drain_q8", 32'(q8.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gray_codec_seq.md
Name: gray_codec_seq

Overview:
- Parametrised, handshaked Gray-code converter.
- Generalises the fixed 4-bit combinational binary-to-Gray block in two ways:
  - arbitrary WIDTH
  - per-transaction mode selecting binary-to-Gray or Gray-to-binary
- Gray-to-binary runs bit-serially, one bit per clock, to keep the XOR chain out of the critical path.
- Sits between a producer and consumer that each use valid/ready handshakes.

Parameters:
WIDTH, 4, data width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  producer has a request
in_ready  output  1  block can accept a request
in_mode  input  1  0 = binary-to-Gray, 1 = Gray-to-binary
in_data  input  WIDTH  value to convert
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  converted value
out_mode  output  1  mode of the transaction that produced out_data
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low: when rst_n = 0 at a rising edge, state <= IDLE, out_valid <= 0, out_data <= 0, out_mode <= 0, internal work registers <= 0.
  - in_ready = (state == IDLE) && rst_n, so it is 0 while reset is held.
  - busy = (state != IDLE).
- States: IDLE, CONV, HOLD.
- Accept: a request is accepted on an edge where in_valid && in_ready. in_data and in_mode are ignored on every other edge.
- IDLE, mode 0 (binary-to-Gray):
  - On accept, out_data <= in_data ^ (in_data >> 1), out_mode <= 0, out_valid <= 1, next state HOLD.
  - Latency: 1 cycle, i.e. out_valid is high in the cycle after the accept edge.
- IDLE, mode 1 (Gray-to-binary):
  - On accept, capture in_data into a Gray shadow register g.
  - Set out_data[WIDTH-1] <= g[WIDTH-1] and clear the lower bits.
  - Set bit index i <= WIDTH-2, out_mode <= 1, next state CONV.
- CONV:
  - Each edge: out_data[i] <= out_data[i+1] ^ g[i], then i <= i-1.
  - The edge that resolves i = 0 sets out_valid <= 1 and moves to HOLD.
  - Latency: WIDTH cycles from the accept cycle to the first out_valid cycle; busy is high throughout.
  - out_valid stays 0 during CONV; partial out_data is not guaranteed meaningful.
- HOLD:
  - out_valid = 1; out_data and out_mode are held stable.
  - On an edge with out_ready = 1: out_valid <= 0, next state IDLE.
  - No back-to-back acceptance: in_ready rises the cycle after the result handshake.
  - Minimum period per transaction: 2 cycles for mode 0, WIDTH+1 cycles for mode 1.
- Backpressure: out_ready may stay low indefinitely; the block holds in HOLD with in_ready = 0.
- Reset mid-operation: rst_n = 0 in CONV or HOLD discards the transaction. All outputs return to their reset values at that edge. The first request after reset release is processed normally.
- Index counter width: $clog2(WIDTH). Mode 0 handles all WIDTH-bit values; mode 1 handles all WIDTH-bit Gray values. No error cases.
- out_valid, out_data and out_mode are registered outputs; in_ready and busy are decoded from state only.

Test Plan:
1. WIDTH=4, mode 0, in_data=4'b1001, out_ready=1 -> out_data=4'b1101, out_mode=0, out_valid high exactly in cycle 1, in_ready high again in cycle 2.
2. WIDTH=4, mode 1, in_data=4'b1101 -> busy=1 in cycles 1-3, out_valid=0 in cycles 1-3, out_valid=1 in cycle 4 with out_data=4'b1001, out_mode=1.
3. WIDTH=8 round trip -> mode 0 with 8'hA5 gives 8'hF7 in cycle 1; mode 1 with 8'hF7 gives 8'hA5 in cycle 8.
4. WIDTH=4 boundaries:
   - mode 0, 4'b1111 -> 4'b1000
   - mode 0, 4'b0000 -> 4'b0000
   - mode 1, 4'b1111 -> 4'b1010
   - mode 1, 4'b1000 -> 4'b1111
5. Backpressure: mode 0 with 4'b0110 and out_ready=0 for 5 cycles, while in_valid=1 with a different in_data -> out_data held at 4'b0101, in_ready=0 throughout, second request not taken until the cycle after out_ready=1.
6. Reset mid-CONV: WIDTH=4, mode 1, rst_n=0 at the cycle-2 edge -> out_valid=0, out_data=0, busy=0, in_ready=0 while reset is held. After release, mode 1 with 4'b0011 -> 4'b0010 in cycle 4.
